// File: rtl/bfup_pkg.sv
// bfup_pkg: definitions shared by the brainfuck_uP port peripherals.
//   bfup_tx_state_t    : UART transmitter FSM states
//   BFUP_TX_DATA_BITS  : data bits per UART frame
//   BFUP_TX_IDLE_LEVEL : line level while no frame is being sent
// Build option: BFUP_TX_PARITY_EN adds the StParity state (8E1 frames).
package bfup_pkg;

  localparam int unsigned BFUP_TX_DATA_BITS  = 8;
  localparam logic        BFUP_TX_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef BFUP_TX_PARITY_EN
    StParity,
`endif
    StStop
  } bfup_tx_state_t;

endpackage

// File: rtl/bf_uart_tx_port_if.sv
// bf_uart_tx_port_if: connects the core's output port to the UART transmitter.
//   portWR, outPort : byte write from the core (master drives)
//   tx              : serial line
//   busy            : frame in progress or bytes still queued
//   overflow        : sticky dropped-write flag
//   fifo_count      : queued bytes, 0..2^FIFO_AW
interface bf_uart_tx_port_if #(
  parameter int unsigned FIFO_AW = 4
);
  logic                                   portWR;
  logic [bfup_pkg::BFUP_TX_DATA_BITS-1:0] outPort;
  logic                                   tx;
  logic                                   busy;
  logic                                   overflow;
  logic [FIFO_AW:0]                       fifo_count;

  modport master (
    output portWR, outPort,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  portWR, outPort,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/bfup_sync_fifo.sv
// bfup_sync_fifo: single-clock FIFO, depth 2^AddrW.
//   bfup_clk, reset : clock, synchronous active-high reset
//   push, wrData    : write request; accepted when not full, or when full with a pop
//   pop, rdData     : rdData shows the head entry; pop removes it (ignored when empty)
//   full, empty     : occupancy flags
//   count           : occupancy, 0..2^AddrW
module bfup_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             bfup_clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wrData,
  output logic [Width-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [AddrW:0]   count
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem [Depth];
  // One extra pointer bit tells full from empty when the low bits match.
  logic [AddrW:0]   wrPtrQ, rdPtrQ;
  logic             doPush, doPop;

  assign empty = (wrPtrQ == rdPtrQ);
  assign full  = (wrPtrQ[AddrW] != rdPtrQ[AddrW]) &&
                 (wrPtrQ[AddrW-1:0] == rdPtrQ[AddrW-1:0]);
  assign count = wrPtrQ - rdPtrQ;

  assign doPop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign doPush = push & (~full | doPop);

  assign rdData = mem[rdPtrQ[AddrW-1:0]];

  always_ff @(posedge bfup_clk) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
    end
  end

  always_ff @(posedge bfup_clk) begin
    if (doPush) mem[wrPtrQ[AddrW-1:0]] <= wrData;
  end

endmodule

// File: rtl/bf_uart_tx_port.sv
// bf_uart_tx_port: buffers bytes written by brainfuck_uP and sends them as UART frames.
//   bfup_clk, reset : clock, synchronous active-high reset
//   port (slave)    : portWR/outPort in; tx, busy, overflow, fifo_count out
// Parameters: CLKS_PER_BIT (>= 2) clocks per bit, FIFO_AW FIFO address width.
// Build option: BFUP_TX_PARITY_EN sends 8E1 frames; default is 8N1.
module bf_uart_tx_port
  import bfup_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic              bfup_clk,
  input  logic              reset,
  bf_uart_tx_port_if.slave  port
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(BFUP_TX_DATA_BITS);
  localparam logic [BitW-1:0]  LastBit  = BitW'(BFUP_TX_DATA_BITS - 1);
  localparam logic [BaudW-1:0] LastBaud = BaudW'(CLKS_PER_BIT - 1);

  bfup_tx_state_t                stateQ, stateD;
  logic [BaudW-1:0]              baudQ, baudD;
  logic [BitW-1:0]               bitQ, bitD;
  logic [BFUP_TX_DATA_BITS-1:0]  shiftQ, shiftD;
  logic                          txQ, txD;
  logic                          overflowQ;
`ifdef BFUP_TX_PARITY_EN
  logic                          parityQ, parityD;
`endif

  logic [BFUP_TX_DATA_BITS-1:0]  rdData;
  logic                          fifoFull, fifoEmpty, pop;
  logic [FIFO_AW:0]              fifoCount;
  logic                          bitDone;

  bfup_sync_fifo #(
    .Width (BFUP_TX_DATA_BITS),
    .AddrW (FIFO_AW)
  ) uFifo (
    .bfup_clk (bfup_clk),
    .reset    (reset),
    .push     (port.portWR),
    .pop      (pop),
    .wrData   (port.outPort),
    .rdData   (rdData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign bitDone = (baudQ == LastBaud);

  always_comb begin
    stateD  = stateQ;
    baudD   = baudQ;
    bitD    = bitQ;
    shiftD  = shiftQ;
    pop     = 1'b0;
`ifdef BFUP_TX_PARITY_EN
    parityD = parityQ;
`endif

    unique case (stateQ)
      StIdle: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shiftD  = rdData;
          baudD   = '0;
          bitD    = '0;
`ifdef BFUP_TX_PARITY_EN
          parityD = ^rdData;
`endif
          stateD  = StStart;
        end
      end
      StStart: begin
        if (bitDone) begin
          baudD  = '0;
          stateD = StData;
        end else begin
          baudD = baudQ + BaudW'(1);
        end
      end
      StData: begin
        if (bitDone) begin
          baudD  = '0;
          shiftD = {1'b0, shiftQ[BFUP_TX_DATA_BITS-1:1]};
          if (bitQ == LastBit) begin
`ifdef BFUP_TX_PARITY_EN
            stateD = StParity;
`else
            stateD = StStop;
`endif
          end else begin
            bitD = bitQ + BitW'(1);
          end
        end else begin
          baudD = baudQ + BaudW'(1);
        end
      end
`ifdef BFUP_TX_PARITY_EN
      StParity: begin
        if (bitDone) begin
          baudD  = '0;
          stateD = StStop;
        end else begin
          baudD = baudQ + BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (bitDone) begin
          baudD = '0;
          // Chain straight into the next start bit so bursts have no idle gap.
          if (!fifoEmpty) begin
            pop     = 1'b1;
            shiftD  = rdData;
            bitD    = '0;
`ifdef BFUP_TX_PARITY_EN
            parityD = ^rdData;
`endif
            stateD  = StStart;
          end else begin
            stateD = StIdle;
          end
        end else begin
          baudD = baudQ + BaudW'(1);
        end
      end
      default: stateD = StIdle;
    endcase

    // Line level is decoded from the next state so tx comes straight from a flop.
    txD = BFUP_TX_IDLE_LEVEL;
    unique case (stateD)
      StStart:  txD = 1'b0;
      StData:   txD = shiftD[0];
`ifdef BFUP_TX_PARITY_EN
      StParity: txD = parityD;
`endif
      default:  txD = BFUP_TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge bfup_clk) begin
    if (reset) begin
      stateQ    <= StIdle;
      baudQ     <= '0;
      bitQ      <= '0;
      shiftQ    <= '0;
      txQ       <= BFUP_TX_IDLE_LEVEL;
      overflowQ <= 1'b0;
`ifdef BFUP_TX_PARITY_EN
      parityQ   <= 1'b0;
`endif
    end else begin
      stateQ    <= stateD;
      baudQ     <= baudD;
      bitQ      <= bitD;
      shiftQ    <= shiftD;
      txQ       <= txD;
      // A write into a full FIFO is dropped unless a pop frees a slot this cycle.
      overflowQ <= overflowQ | (port.portWR & fifoFull & ~pop);
`ifdef BFUP_TX_PARITY_EN
      parityQ   <= parityD;
`endif
    end
  end

  assign port.tx         = txQ;
  assign port.busy       = (stateQ != StIdle) | ~fifoEmpty;
  assign port.overflow   = overflowQ;
  assign port.fifo_count = fifoCount;

endmodule

// File: tb/tb_bf_uart_tx_port.sv
// tb_bf_uart_tx_port: randomized and directed bench for bf_uart_tx_port with a
// frame-level reference model and an independent UART receiver on tx.
module tb_bf_uart_tx_port;

  localparam int C     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef BFUP_TX_PARITY_EN
  localparam int FRAME = 11 * C;
`else
  localparam int FRAME = 10 * C;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf_uart_tx_port_if #(.FIFO_AW(AW)) txIf ();

  bf_uart_tx_port #(
    .CLKS_PER_BIT (C),
    .FIFO_AW      (AW)
  ) dut (
    .bfup_clk (clk),
    .reset    (rst),
    .port     (txIf)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: queued bytes, byte on the wire, cycles left in its frame.
  logic [7:0] mq[$];
  logic [7:0] mCur;
  int         mRemain;
  logic       mOvf;
  logic [7:0] sentQ[$];

  // Receiver state.
  logic [7:0] rxQ[$];
  logic       rxActive;
  int         rxPos;
  logic [7:0] rxByte;
  int         peak;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic popNow, fullNow, expTx;
    int   pos;
    txIf.portWR  = w;
    txIf.outPort = d;
    rst          = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mRemain = 0;
      mOvf    = 1'b0;
    end else begin
      popNow  = (mRemain <= 1) && (mq.size() > 0);
      fullNow = (mq.size() == DEPTH);
      if (mRemain == 1) sentQ.push_back(mCur);
      if (popNow) mCur = mq.pop_front();
      if (w) begin
        if (!fullNow || popNow) mq.push_back(d);
        else mOvf = 1'b1;
      end
      if (popNow) mRemain = FRAME;
      else if (mRemain > 0) mRemain--;
    end
    @(negedge clk);
    expTx = 1'b1;
    if (mRemain > 0) begin
      pos = (FRAME - mRemain) / C;
      if (pos == 0) expTx = 1'b0;
      else if (pos <= 8) expTx = mCur[pos-1];
`ifdef BFUP_TX_PARITY_EN
      else if (pos == 9) expTx = ^mCur;
`endif
    end
    check("tx", txIf.tx, expTx);
    check("fifo_count", txIf.fifo_count, mq.size());
    check("busy", txIf.busy, (mRemain > 0) || (mq.size() > 0));
    check("overflow", txIf.overflow, mOvf);
    if (int'(txIf.fifo_count) > peak) peak = int'(txIf.fifo_count);
    // Receiver samples tx mid-bit, timed from the first low cycle of a frame.
    if (r) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (txIf.tx == 1'b0) begin
        rxActive = 1'b1;
        rxPos    = 0;
        rxByte   = '0;
      end
    end else begin
      rxPos++;
      if ((rxPos % C) == (C / 2) && (rxPos / C) >= 1 && (rxPos / C) <= 8)
        rxByte[(rxPos / C) - 1] = txIf.tx;
      if (rxPos == FRAME - 1) begin
        rxQ.push_back(rxByte);
        rxActive = 1'b0;
      end
    end
  endtask

  task automatic clearLogs();
    rxQ.delete();
    sentQ.delete();
    peak = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (mRemain == 0 && mq.size() == 0) break;
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("rx_vs_model_len", rxQ.size(), sentQ.size());
    for (int i = 0; i < rxQ.size() && i < sentQ.size(); i++)
      check("rx_vs_model_byte", rxQ[i], sentQ[i]);
  endtask

  task automatic checkRx(input string tag, input logic [7:0] expq[$]);
    check(tag, rxQ.size(), expq.size());
    for (int i = 0; i < rxQ.size() && i < expq.size(); i++) check(tag, rxQ[i], expq[i]);
  endtask

  task automatic waitBitPos(input int bitPos);
    for (int i = 0; i < 200; i++) begin
      if (mRemain > 0 && (FRAME - mRemain) / C == bitPos) break;
      step(1'b0, 8'h00, 1'b0);
    end
  endtask

  logic [7:0] expq[$];

  initial begin
    rxActive = 1'b0;
    rxPos    = 0;
    rxByte   = '0;
    mRemain  = 0;
    mOvf     = 1'b0;
    mCur     = '0;
    peak     = 0;
    txIf.portWR  = 1'b0;
    txIf.outPort = '0;
    rst          = 1'b1;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("rst_tx", txIf.tx, 1);
    check("rst_busy", txIf.busy, 0);
    check("rst_overflow", txIf.overflow, 0);
    check("rst_fifo_count", txIf.fifo_count, 0);

    // Single byte with start-bit latency.
    clearLogs();
    step(1'b1, 8'h41, 1'b0);
    check("single_n1_tx", txIf.tx, 1);
    check("single_n1_count", txIf.fifo_count, 1);
    step(1'b0, 8'h00, 1'b0);
    check("single_n2_tx", txIf.tx, 0);
    drain();
    check("single_busy_end", txIf.busy, 0);
    expq = {8'h41};
    checkRx("single_rx", expq);

    // Burst of four.
    clearLogs();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    drain();
    check("burst_peak", peak, 3);
    check("burst_overflow", txIf.overflow, 0);
    expq = {8'h00, 8'hFF, 8'h55, 8'hAA};
    checkRx("burst_rx", expq);

    // Six writes: the sixth is dropped.
    clearLogs();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    check("ovf_set", txIf.overflow, 1);
    drain();
    check("ovf_sticky", txIf.overflow, 1);
    expq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    checkRx("ovf_rx", expq);
    step(1'b0, 8'h00, 1'b1);
    check("ovf_cleared", txIf.overflow, 0);

    // Write into a full FIFO on the cycle the stop bit pops.
    clearLogs();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (mRemain == 1 && mq.size() == DEPTH) break;
      step(1'b0, 8'h00, 1'b0);
    end
    check("pfp_full_before", txIf.fifo_count, 4);
    step(1'b1, 8'h25, 1'b0);
    check("pfp_overflow", txIf.overflow, 0);
    check("pfp_count", txIf.fifo_count, 4);
    drain();
    expq = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    checkRx("pfp_rx", expq);

    // Reset during data bit 3.
    clearLogs();
    step(1'b1, 8'h0F, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    waitBitPos(4);
    step(1'b0, 8'h00, 1'b1);
    check("rstmid_tx", txIf.tx, 1);
    check("rstmid_count", txIf.fifo_count, 0);
    check("rstmid_busy", txIf.busy, 0);
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00, 1'b0);
    check("rstmid_no_frames", rxQ.size(), 0);

`ifdef BFUP_TX_PARITY_EN
    clearLogs();
    step(1'b1, 8'h07, 1'b0);
    waitBitPos(9);
    check("parity_07", txIf.tx, 1);
    drain();
    step(1'b1, 8'h03, 1'b0);
    waitBitPos(9);
    check("parity_03", txIf.tx, 0);
    drain();
`endif

    // Randomized traffic alternating busy and quiet phases, with rare resets.
    clearLogs();
    for (int i = 0; i < 3000; i++) begin
      logic w, r;
      r = ($urandom_range(0, 999) == 0);
      w = ($urandom_range(0, 99) < (((i / 200) % 2 == 0) ? 4 : 50));
      step(w, 8'($urandom_range(0, 255)), r);
    end
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
